// File: rtl/snake_pkg.sv
// snake_pkg: playfield geometry, trail counter width and the saturation helper.
package snake_pkg;
    localparam int GRID_W    = 16;
    localparam int GRID_H    = 12;
    localparam int NUM_CELLS = GRID_W * GRID_H;
    localparam int CNT_W     = 10;
    typedef logic [$clog2(NUM_CELLS)-1:0] cell_idx_t;
    function automatic int unsigned sat(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction
endpackage

// File: rtl/trail_cell.sv
// trail_cell: one saturating trail counter with its occupancy and collision terms.
// SNAKE_TRAIL_QUERY_EN exposes the raw count for the age query mux.
module trail_cell #(
    parameter int CNT_W = snake_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic             clear,
    input  logic             hit,
    input  logic [CNT_W-1:0] len,
    output logic             occ,
    output logic             coll
`ifdef SNAKE_TRAIL_QUERY_EN
    ,
    output logic [CNT_W-1:0] age
`endif
);
    import snake_pkg::*;
    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat(CNT_W));
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   inc;
    // inc is one bit wider so cnt+1 at SAT still compares correctly against len
    always_comb begin
        inc  = {1'b0, cnt} + (CNT_W+1)'(1);
        occ  = cnt < len;
        coll = hit && (inc < {1'b0, len});
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= SAT;
        else if (clear)
            cnt <= SAT;
        else if (tick)
            cnt <= hit ? '0 : (cnt == SAT ? SAT : inc[CNT_W-1:0]);
    end
`ifdef SNAKE_TRAIL_QUERY_EN
    assign age = cnt;
`endif
endmodule

// File: rtl/snake_trail_bank.sv
// snake_trail_bank: per-cell trail counters, occupancy map and head-into-body collision.
// Optional SNAKE_TRAIL_QUERY_EN adds a registered per-cell age read port (q_addr/q_age).
module snake_trail_bank #(
    parameter int  NUM_CELLS = snake_pkg::NUM_CELLS,
    parameter int  CNT_W     = snake_pkg::CNT_W,
    localparam int ADDR_W    = $clog2(NUM_CELLS)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 tick,
    input  logic                 visit_valid,
    input  logic [ADDR_W-1:0]    visit_addr,
    input  logic [CNT_W-1:0]     len,
    input  logic                 clear,
    output logic [NUM_CELLS-1:0] occ,
    output logic                 collision
`ifdef SNAKE_TRAIL_QUERY_EN
    ,
    input  logic [ADDR_W-1:0]    q_addr,
    output logic [CNT_W-1:0]     q_age
`endif
);
    import snake_pkg::*;
    logic [NUM_CELLS-1:0] coll;
`ifdef SNAKE_TRAIL_QUERY_EN
    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat(CNT_W));
    logic [CNT_W-1:0] age [NUM_CELLS];
`endif
    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        trail_cell #(.CNT_W(CNT_W)) u_cell (
            .clk    (clk),
            .resetn (resetn),
            .tick   (tick),
            .clear  (clear),
            .hit    (tick && visit_valid && visit_addr == ADDR_W'(g)),
            .len    (len),
            .occ    (occ[g]),
            .coll   (coll[g])
`ifdef SNAKE_TRAIL_QUERY_EN
            ,
            .age    (age[g])
`endif
        );
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            collision <= 1'b0;
        else
            collision <= !clear && |coll;
    end
`ifdef SNAKE_TRAIL_QUERY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            q_age <= SAT;
        else
            q_age <= (32'(q_addr) < NUM_CELLS) ? age[q_addr] : SAT;
    end
`endif
endmodule

// File: tb/tb_snake_trail_bank.sv
// tb_snake_trail_bank: directed vector table plus hand-written corner sequences.
module tb_snake_trail_bank;
    import snake_pkg::*;
    localparam int N = NUM_CELLS;

    logic clk = 1'b0, resetn = 1'b0, tick = 1'b0, visit_valid = 1'b0, clear = 1'b0;
    cell_idx_t visit_addr = '0;
    logic [9:0] len = 10'd3;
    logic [2:0] len3 = 3'd7;
    logic [N-1:0] occ, occ3;
    logic collision, collision3;
`ifdef SNAKE_TRAIL_QUERY_EN
    cell_idx_t q_addr = cell_idx_t'(2);
    logic [9:0] q_age;
    logic [2:0] q_age3;
`endif

    snake_trail_bank dut (
        .clk(clk), .resetn(resetn), .tick(tick), .visit_valid(visit_valid),
        .visit_addr(visit_addr), .len(len), .clear(clear), .occ(occ), .collision(collision)
`ifdef SNAKE_TRAIL_QUERY_EN
        , .q_addr(q_addr), .q_age(q_age)
`endif
    );

    snake_trail_bank #(.CNT_W(3)) dut3 (
        .clk(clk), .resetn(resetn), .tick(tick), .visit_valid(visit_valid),
        .visit_addr(visit_addr), .len(len3), .clear(clear), .occ(occ3), .collision(collision3)
`ifdef SNAKE_TRAIL_QUERY_EN
        , .q_addr(q_addr), .q_age(q_age3)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       t, vv, clr;
        logic [7:0] a;
        logic [9:0] l;
        logic [15:0] o;
        logic       c;
    } vec_t;
    vec_t vecs[$];
    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic t, vv, clr, input logic [7:0] a, input logic [9:0] l,
                       input logic [15:0] o, input logic c);
        vecs.push_back('{t, vv, clr, a, l, o, c});
    endtask

    task automatic apply(input logic t, vv, clr, input logic [7:0] a, input logic [9:0] l);
        tick = t; visit_valid = vv; clear = clr; visit_addr = a; len = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 3, 16'h0000, 0);
        add(1, 1, 0, 5, 3, 16'h0020, 0);
        add(1, 1, 0, 6, 3, 16'h0060, 0);
        add(1, 1, 0, 7, 3, 16'h00E0, 0);
        add(1, 1, 0, 8, 3, 16'h01C0, 0);
        add(0, 1, 0, 9, 3, 16'h01C0, 0);
        add(1, 0, 0, 0, 3, 16'h0180, 0);
        add(1, 0, 0, 0, 3, 16'h0100, 0);
        add(1, 0, 0, 0, 3, 16'h0000, 0);
        add(0, 0, 1, 0, 4, 16'h0000, 0);
        add(1, 1, 0, 10, 4, 16'h0400, 0);
        add(1, 1, 0, 11, 4, 16'h0C00, 0);
        add(1, 1, 0, 12, 4, 16'h1C00, 0);
        add(1, 1, 0, 13, 4, 16'h3C00, 0);
        add(1, 1, 0, 10, 4, 16'h3C00, 0);
        add(1, 0, 0, 0, 4, 16'h3400, 0);
        add(0, 0, 1, 0, 5, 16'h0000, 0);
        add(1, 1, 0, 10, 5, 16'h0400, 0);
        add(1, 1, 0, 11, 5, 16'h0C00, 0);
        add(1, 1, 0, 12, 5, 16'h1C00, 0);
        add(1, 1, 0, 13, 5, 16'h3C00, 0);
        add(1, 1, 0, 10, 5, 16'h3C00, 1);
        add(0, 0, 0, 0, 5, 16'h3C00, 0);
        add(1, 1, 1, 11, 5, 16'h0000, 0);
        add(1, 1, 0, 1, 5, 16'h0002, 0);
        add(1, 1, 0, 200, 5, 16'h0002, 0);
        add(1, 1, 0, 1, 5, 16'h0002, 1);
        add(0, 0, 0, 0, 1, 16'h0002, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 0);
        add(1, 1, 0, 3, 0, 16'h0000, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset occ", occ, '0);
        check("reset collision", N'(collision), '0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].t, vecs[i].vv, vecs[i].clr, vecs[i].a, vecs[i].l);
            step();
            check($sformatf("vec%0d occ", i), occ, N'(vecs[i].o));
            check($sformatf("vec%0d collision", i), N'(collision), N'(vecs[i].c));
        end

        apply(0, 0, 1, 0, 7);
        step();
        apply(1, 1, 0, 0, 7);
        step();
        check("sat visit occ3", occ3, N'(1));
        for (int i = 1; i <= 19; i++) begin
            apply(1, 0, 0, 0, 7);
            step();
            check($sformatf("sat tick%0d occ3", i), occ3, (i < 7) ? N'(1) : N'(0));
        end
        check("sat main occ", occ, '0);
        check("sat collision3", N'(collision3), '0);

        apply(1, 1, 0, 2, 5);
        step();
        step();
        check("pre-reset collision", N'(collision), N'(1));
        check("pre-reset occ", occ, N'(4));
        apply(0, 0, 0, 0, 5);
        #2 resetn = 1'b0;
        #1;
        check("async reset occ", occ, '0);
        check("async reset collision", N'(collision), '0);
        check("async reset occ3", occ3, '0);
`ifdef SNAKE_TRAIL_QUERY_EN
        check("async reset q_age", N'(q_age), N'(10'h3FF));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
